// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared types and constants for the multicycle RV32I sequencer
// Holds the state enum, opcode values, ALU operation codes, mux select codes
// and the opcode-class enum with its classify() helper.
package control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALUOP_R      = 4'b0000;
  localparam logic [3:0] ALUOP_I      = 4'b1100;
  localparam logic [3:0] ALUOP_ADD    = 4'b1110;
  localparam logic [3:0] ALUOP_STORE  = 4'b0001;
  localparam logic [3:0] ALUOP_BRANCH = 4'b1111;
  localparam logic [3:0] ALUOP_LUI    = 4'b0011;
  localparam logic [3:0] ALUOP_AUIPC  = 4'b0111;
  localparam logic [3:0] ALUOP_JAL    = 4'b0010;
  localparam logic [3:0] ALUOP_JALR   = 4'b0100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_PCOLD = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
  } opclass_t;

  function automatic opclass_t classify(input logic [6:0] op);
    case (op)
      OP_R:      return CLS_R;
      OP_I:      return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      OP_JAL:    return CLS_JAL;
      OP_JALR:   return CLS_JALR;
      OP_LUI:    return CLS_LUI;
      OP_AUIPC:  return CLS_AUIPC;
      default:   return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multicycle FETCH/DECODE/EXEC/MEM/WB sequencer
// Inputs : CLK, RESET_N (async, active-low), opcode (IR[6:0]), br_taken, mem_ready
// Outputs: mem_req/mem_we/IorD memory handshake, IRWrite/PCWrite/RegWrite enables,
//          PCSrc/ALUSrcA/ALUSrcB/ALUOp/MemtoReg selects, instr_done/illegal pulses,
//          state (debug).
module control_multiciclo
  import control_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       PCSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] MemtoReg,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
);

  state_t   r_state;
  opclass_t r_cls;
  state_t   w_next;
  opclass_t w_cls;

  // IR is valid from DECODE on; classify it live there, use the registered class later
  assign w_cls = classify(opcode);
  assign state = r_state;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_FETCH;
      r_cls   <= CLS_ILLEGAL;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_cls;
    end
  end

  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    PCSrc      = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUOp      = ALUOP_R;
    MemtoReg   = M2R_ALUOUT;
    instr_done = 1'b0;
    illegal    = 1'b0;
    // While reset is held every output is forced to its idle value, so an
    // in-flight request drops immediately rather than at the next edge.
    if (RESET_N) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = SRCB_FOUR;
          ALUOp   = ALUOP_ADD;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            w_next  = S_DECODE;
          end
        end
        S_DECODE: begin
          // ALUOut captures PCold + imm: the branch/JAL target
          ALUSrcA = SRCA_PCOLD;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_ADD;
          if (w_cls == CLS_ILLEGAL) begin
            illegal = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_next  = S_EXEC;
          end
        end
        S_EXEC: begin
          w_next = S_WB;
          case (r_cls)
            CLS_R: begin
              ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_RS2; ALUOp = ALUOP_R;
            end
            CLS_I: begin
              ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ALUOp = ALUOP_I;
            end
            CLS_LOAD: begin
              ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ALUOp = ALUOP_ADD;
              w_next  = S_MEM;
            end
            CLS_STORE: begin
              ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ALUOp = ALUOP_STORE;
              w_next  = S_MEM;
            end
            CLS_BRANCH: begin
              ALUSrcA    = SRCA_RS1; ALUSrcB = SRCB_RS2; ALUOp = ALUOP_BRANCH;
              PCSrc      = 1'b1;
              PCWrite    = br_taken;
              instr_done = 1'b1;
              w_next     = S_FETCH;
            end
            CLS_JAL: begin
              ALUSrcA = SRCA_PCOLD; ALUSrcB = SRCB_IMM; ALUOp = ALUOP_JAL;
              PCWrite = 1'b1; PCSrc = 1'b1;
            end
            CLS_JALR: begin
              // live ALU result; the datapath clears bit 0 of the target
              ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ALUOp = ALUOP_JALR;
              PCWrite = 1'b1; PCSrc = 1'b0;
            end
            CLS_LUI: begin
              ALUSrcA = SRCA_ZERO; ALUSrcB = SRCB_IMM; ALUOp = ALUOP_LUI;
            end
            CLS_AUIPC: begin
              ALUSrcA = SRCA_PCOLD; ALUSrcB = SRCB_IMM; ALUOp = ALUOP_AUIPC;
            end
            default: w_next = S_FETCH;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
          mem_we  = (r_cls == CLS_STORE);
          if (mem_ready) begin
            if (r_cls == CLS_STORE) begin
              instr_done = 1'b1;
              w_next     = S_FETCH;
            end else begin
              w_next     = S_WB;
            end
          end
        end
        S_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          if (r_cls == CLS_LOAD) MemtoReg = M2R_MDR;
          else if (r_cls == CLS_JAL || r_cls == CLS_JALR) MemtoReg = M2R_PC;
          w_next = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// tb/tb_control_multiciclo.sv - scoreboard bench for control_multiciclo
module tb_control_multiciclo;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [6:0] opcode;
  logic       br_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, PCSrc;
  logic [1:0] ALUSrcA, ALUSrcB, MemtoReg;
  logic [3:0] ALUOp;
  logic       instr_done, illegal;
  logic [2:0] state;

  control_multiciclo dut (
    .CLK(CLK), .RESET_N(RESET_N), .opcode(opcode), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemtoReg(MemtoReg),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 CLK = ~CLK;

  // {state, req, we, IorD, IRWrite, PCWrite, RegWrite, PCSrc, A, B, ALUOp, MemtoReg, done, illegal}
  logic [21:0] w_obs;
  assign w_obs = {state, mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, PCSrc,
                  ALUSrcA, ALUSrcB, ALUOp, MemtoReg, instr_done, illegal};

  typedef struct {
    string       tag;
    logic [21:0] v;
  } sb_t;
  sb_t sb_q[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] mk(input logic [2:0] st, input logic req, we, iord,
                                     irw, pcw, rw, pcsrc, input logic [1:0] a, b,
                                     input logic [3:0] op, input logic [1:0] m2r,
                                     input logic done, ill);
    return {st, req, we, iord, irw, pcw, rw, pcsrc, a, b, op, m2r, done, ill};
  endfunction

  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check(e.tag, w_obs, e.v);
    end
  end

  task automatic push(input string tag, input logic [21:0] v);
    sb_t e;
    e.tag = tag;
    e.v   = v;
    sb_q.push_back(e);
  endtask

  task automatic step(input string tag, input logic [6:0] opc, input logic br,
                      input logic rdy, input logic [21:0] v);
    @(posedge CLK);
    #1;
    opcode    = opc;
    br_taken  = br;
    mem_ready = rdy;
    push(tag, v);
  endtask

  logic [21:0] F1, F0, D, DI, Z;

  // zero-wait instruction with an EXEC and a WB cycle
  task automatic run4(input string tag, input logic [6:0] opc,
                      input logic [21:0] ex, input logic [21:0] wb);
    step({tag, "_fetch"}, opc, 1'b0, 1'b1, F1);
    step({tag, "_decode"}, opc, 1'b0, 1'b1, D);
    step({tag, "_exec"}, opc, 1'b0, 1'b1, ex);
    step({tag, "_wb"}, opc, 1'b0, 1'b1, wb);
  endtask

  initial begin
    F1 = mk(3'd0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b01, 4'b1110, 2'b00, 0, 0);
    F0 = mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 4'b1110, 2'b00, 0, 0);
    D  = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 4'b1110, 2'b00, 0, 0);
    DI = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 4'b1110, 2'b00, 0, 1);
    Z  = 22'd0;

    RESET_N = 1'b0; opcode = 7'b0110011; br_taken = 1'b0; mem_ready = 1'b1;
    step("reset0", 7'b0110011, 0, 1, Z);
    step("reset1", 7'b0110011, 0, 1, Z);
    @(posedge CLK); #1;
    RESET_N = 1'b1; mem_ready = 1'b0;
    push("first_req", F0);

    // ADD
    run4("add", 7'b0110011,
         mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0000, 2'b00, 0, 0),
         mk(3'd4, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 1, 0));

    // LW with three wait cycles in MEM
    step("lw_fetch", 7'b0000011, 0, 1, F1);
    step("lw_decode", 7'b0000011, 0, 1, D);
    step("lw_exec", 7'b0000011, 0, 1,
         mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 4'b1110, 2'b00, 0, 0));
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", 7'b0000011, 0, 0,
           mk(3'd3, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 0, 0));
    step("lw_mem_ready", 7'b0000011, 0, 1,
         mk(3'd3, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 0, 0));
    step("lw_wb", 7'b0000011, 0, 1,
         mk(3'd4, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 2'b01, 1, 0));

    // BEQ taken, then not taken; fetch wait cycle before the second one
    step("beq_t_fetch", 7'b1100011, 1, 1, F1);
    step("beq_t_decode", 7'b1100011, 1, 1, D);
    step("beq_t_exec", 7'b1100011, 1, 1,
         mk(3'd2, 0, 0, 0, 0, 1, 0, 1, 2'b01, 2'b00, 4'b1111, 2'b00, 1, 0));
    step("beq_n_fetch_wait", 7'b1100011, 0, 0, F0);
    step("beq_n_fetch", 7'b1100011, 0, 1, F1);
    step("beq_n_decode", 7'b1100011, 0, 1, D);
    step("beq_n_exec", 7'b1100011, 0, 1,
         mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 4'b1111, 2'b00, 1, 0));

    run4("jalr", 7'b1100111,
         mk(3'd2, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b10, 4'b0100, 2'b00, 0, 0),
         mk(3'd4, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 2'b10, 1, 0));
    run4("jal", 7'b1101111,
         mk(3'd2, 0, 0, 0, 0, 1, 0, 1, 2'b10, 2'b10, 4'b0010, 2'b00, 0, 0),
         mk(3'd4, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 2'b10, 1, 0));
    run4("addi", 7'b0010011,
         mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 4'b1100, 2'b00, 0, 0),
         mk(3'd4, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 1, 0));
    run4("lui", 7'b0110111,
         mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b10, 4'b0011, 2'b00, 0, 0),
         mk(3'd4, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 1, 0));
    run4("auipc", 7'b0010111,
         mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 4'b0111, 2'b00, 0, 0),
         mk(3'd4, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 1, 0));

    // zero-wait SW
    step("sw_fetch", 7'b0100011, 0, 1, F1);
    step("sw_decode", 7'b0100011, 0, 1, D);
    step("sw_exec", 7'b0100011, 0, 1,
         mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 4'b0001, 2'b00, 0, 0));
    step("sw_mem", 7'b0100011, 0, 1,
         mk(3'd3, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 1, 0));

    // illegal opcode
    step("ill_fetch", 7'b0000000, 0, 1, F1);
    step("ill_decode", 7'b0000000, 0, 1, DI);
    step("ill_back_fetch", 7'b0000000, 0, 0, F0);

    // reset during a stalled SW access
    step("swr_fetch", 7'b0100011, 0, 1, F1);
    step("swr_decode", 7'b0100011, 0, 1, D);
    step("swr_exec", 7'b0100011, 0, 1,
         mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 4'b0001, 2'b00, 0, 0));
    step("swr_mem_wait", 7'b0100011, 0, 0,
         mk(3'd3, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 0, 0));
    @(negedge CLK); #2;
    RESET_N = 1'b0;
    #1;
    check("async_mem_req", {21'd0, mem_req}, 22'd0);
    check("async_mem_we", {21'd0, mem_we}, 22'd0);
    check("async_state", {19'd0, state}, 22'd0);
    step("swr_in_reset", 7'b0100011, 0, 0, Z);
    @(posedge CLK); #1;
    RESET_N = 1'b1; mem_ready = 1'b0;
    push("swr_release", F0);

    run4("add2", 7'b0110011,
         mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0000, 2'b00, 0, 0),
         mk(3'd4, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 1, 0));

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge CLK);
    @(posedge CLK);
    check("scoreboard_drained", 22'(sb_q.size()), 22'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
